// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, rs_val, rt_val, flush,
        input  op_ready, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush,
        output op_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO pair.
// Multiply is a fixed-latency multicycle path; divide is restoring radix-2 plus a sign-fix cycle.
module hilo_muldiv #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input logic         clk,
    input logic         rst,
    hilo_muldiv_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // a_q: multiplicand, or dividend shifting out while quotient bits shift in
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d, rsraw_q, rsraw_d;
    logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic                 accept, dsigned, rs_neg, rt_neg, ge;
    logic [2*WIDTH-1:0]   ax, bx, prod;
    logic [WIDTH:0]       shifted, diff;
    logic [WIDTH-1:0]     q_fix, r_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            mcnt_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            rsraw_q <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            mcnt_q  <= mcnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            rsraw_q <= rsraw_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        mcnt_d  = mcnt_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        rsraw_d = rsraw_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;

        accept  = bus.op_valid && (state_q == ST_IDLE) && !bus.flush;
        dsigned = (bus.op == OP_DIV);
        rs_neg  = dsigned & bus.rs_val[WIDTH-1];
        rt_neg  = dsigned & bus.rt_val[WIDTH-1];

        // Sign-extending to 2*WIDTH makes the truncated product correct for both signednesses
        ax   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        bx   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod = ax * bx;

        shifted = {rem_q, a_q[WIDTH-1]};
        ge      = shifted >= {1'b0, b_q};
        diff    = shifted - {1'b0, b_q};
        q_fix   = qneg_q ? -a_q : a_q;
        r_fix   = rneg_q ? -rem_q : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = bus.rs_val;
                            b_d     = bus.rt_val;
                            sgn_d   = (bus.op == OP_MULT);
                            mcnt_d  = '0;
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = rs_neg ? -bus.rs_val : bus.rs_val;
                            b_d     = rt_neg ? -bus.rt_val : bus.rt_val;
                            rem_d   = '0;
                            qneg_d  = rs_neg ^ rt_neg;
                            rneg_d  = rs_neg;
                            dz_d    = (bus.rt_val == '0);
                            rsraw_d = bus.rs_val;
                            cnt_d   = '0;
                            state_d = ST_DIV;
                        end
                        OP_MTHI: hi_d = bus.rs_val;
                        OP_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (mcnt_q == MW'(MUL_LAT - 1)) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], ge};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    // Most-negative / -1 falls out naturally: the magnitude quotient is unchanged by negation
                    lo_d   = dz_q ? '1 : q_fix;
                    hi_d   = dz_q ? rsraw_q : r_fix;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.op_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
